// File: rtl/mux_pipe_pkg.sv
// Shared types and helpers for the pipelined N-to-1 selector.
package mux_pipe_pkg;

  localparam int unsigned WIDTH_DEF  = 32;
  localparam int unsigned NUM_IN_DEF = 5;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  // Select width, never below one bit.
  function automatic int unsigned sel_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mux_nto1.sv
// Combinational N-to-1 selector; out-of-range selects fall back to input 0.
module mux_nto1
  import mux_pipe_pkg::*;
#(
  parameter int unsigned WIDTH  = WIDTH_DEF,
  parameter int unsigned NUM_IN = NUM_IN_DEF,
  localparam int unsigned SEL_W = sel_width(NUM_IN)
) (
  input  logic [NUM_IN*WIDTH-1:0] data_i,
  input  logic [SEL_W-1:0]        se_i,
  output logic [WIDTH-1:0]        y_o,
  output logic                    range_err_o
);

  always_comb begin
    y_o = data_i[0 +: WIDTH];
    for (int unsigned k = 1; k < NUM_IN; k++) begin
      if (se_i == SEL_W'(k)) y_o = data_i[k*WIDTH +: WIDTH];
    end
  end

  // A full power-of-two select space has no illegal codes.
  if (NUM_IN == (1 << SEL_W)) begin : g_full
    assign range_err_o = 1'b0;
  end else begin : g_range
    assign range_err_o = (se_i >= SEL_W'(NUM_IN));
  end

endmodule

// File: rtl/mux_nto1_pipe.sv
// Selector followed by a 2-entry skid buffer with valid/ready on both sides.
module mux_nto1_pipe
  import mux_pipe_pkg::*;
#(
  parameter int unsigned WIDTH  = WIDTH_DEF,
  parameter int unsigned NUM_IN = NUM_IN_DEF,
  localparam int unsigned SEL_W = sel_width(NUM_IN)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NUM_IN*WIDTH-1:0] data_i,
  input  logic [SEL_W-1:0]        se_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  output logic [WIDTH-1:0]        y_o,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic                    sel_err_o,
  input  logic                    err_clr_i
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             err_q, err_d;
  logic             valid_q, valid_d;
  logic             ready_q, ready_d;
  logic [WIDTH-1:0] mux_y;
  logic             mux_err;
  logic             in_xfer;
  logic             out_xfer;

  mux_nto1 #(
    .WIDTH  (WIDTH),
    .NUM_IN (NUM_IN)
  ) u_mux (
    .data_i      (data_i),
    .se_i        (se_i),
    .y_o         (mux_y),
    .range_err_o (mux_err)
  );

  // ready_q is a flop; the reset gate only blocks transfers during reset.
  assign ready_o   = ready_q & ~rst_i;
  assign valid_o   = valid_q;
  assign y_o       = main_q;
  assign sel_err_o = err_q;

  assign in_xfer  = valid_i & ready_o;
  assign out_xfer = valid_q & ready_i;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    err_d   = err_q;
    unique case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          main_d  = mux_y;
          state_d = ONE;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          main_d = mux_y;
        end else if (in_xfer) begin
          skid_d  = mux_y;
          state_d = TWO;
        end else if (out_xfer) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (out_xfer) begin
          main_d  = skid_q;
          state_d = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
    // A new error wins over a coincident clear.
    if (in_xfer && mux_err) err_d = 1'b1;
    else if (err_clr_i)     err_d = 1'b0;
    valid_d = (state_d != EMPTY);
    ready_d = (state_d != TWO);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
    end
  end

endmodule
